// File: rtl/stab_mon_pkg.sv
// stab_mon_pkg: shared types and run classification for the stability monitor
package stab_mon_pkg;
  typedef enum logic [1:0] {MODE_BOTH, MODE_HIGH, MODE_LOW, MODE_OFF} mode_e;
  typedef enum logic [1:0] {IDLE, RUN, STABLE} chan_state_e;
  function automatic logic class_chk(input logic value, input mode_e mode);
    return (mode == MODE_BOTH) || (mode == MODE_HIGH && value) || (mode == MODE_LOW && !value);
  endfunction
endpackage

// File: rtl/stab_mon_chan.sv
// stab_mon_chan: one channel run-length checker; STAB_MON_ASSERT_EN adds simulation assertions
module stab_mon_chan
  import stab_mon_pkg::*;
#(
  parameter int MIN_STABLE = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  mode_e mode,
  input  logic  sig,
  output logic  pass,
  output logic  fail,
  output logic  fail_next
);
  localparam int LW = $clog2(MIN_STABLE + 1);
  localparam logic [LW-1:0] LEN_MAX = LW'(MIN_STABLE);
  chan_state_e state, state_n;
  logic prev, prev_n, chk, chk_n, pass_n;
  logic [LW-1:0] len, len_n;
  // state register with registered pass/fail pulses
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      prev  <= 1'b0;
      len   <= '0;
      chk   <= 1'b0;
      pass  <= 1'b0;
      fail  <= 1'b0;
    end else begin
      state <= state_n;
      prev  <= prev_n;
      len   <= len_n;
      chk   <= chk_n;
      pass  <= pass_n;
      fail  <= fail_next;
    end
  // next state: first run after IDLE is unchecked, a change in RUN ends a short run
  always_comb begin
    state_n   = state;
    prev_n    = prev;
    len_n     = len;
    chk_n     = chk;
    pass_n    = 1'b0;
    fail_next = 1'b0;
    if (!en) state_n = IDLE;
    else if (state == IDLE) begin
      state_n = RUN;
      prev_n  = sig;
      len_n   = LW'(1);
      chk_n   = 1'b0;
    end else if (sig == prev) begin
      if (state == RUN) begin
        len_n = len + 1'b1;
        state_n = (len_n == LEN_MAX) ? STABLE : RUN;
        pass_n = (len_n == LEN_MAX) && chk;
      end
    end else begin
      fail_next = (state == RUN) && chk;
      state_n   = RUN;
      prev_n    = sig;
      len_n     = LW'(1);
      chk_n     = class_chk(sig, mode);
    end
  end
`ifdef STAB_MON_ASSERT_EN
  a_excl: assert property (@(posedge clk) disable iff (rst) !(pass && fail))
    else $error("%m: pass and fail together at %0t", $time);
  a_fail: assert property (@(posedge clk) disable iff (rst) fail |-> ($past(len) < LEN_MAX))
    else $error("%m: fail after a run of at least MIN_STABLE at %0t", $time);
  a_stab: assert property (@(posedge clk) disable iff (rst)
      (en && $stable(sig)) [* MIN_STABLE] |=> (pass || state == STABLE))
    else $error("%m: stable input without pass or STABLE at %0t", $time);
`endif
endmodule

// File: rtl/signal_stability_monitor.sv
// signal_stability_monitor: multi-channel pulse-width checker with sticky errors and fail counter; STAB_MON_ASSERT_EN enables assertions
module signal_stability_monitor
  import stab_mon_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MIN_STABLE = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] sig,
  output logic [WIDTH-1:0] pass,
  output logic [WIDTH-1:0] fail,
  output logic [WIDTH-1:0] err_sticky,
  output logic [CNT_W-1:0] fail_cnt
);
  localparam int PW = $clog2(WIDTH + 1);
  localparam int SW = CNT_W + PW;
  logic [WIDTH-1:0] fail_next;
  logic [PW-1:0] fail_pop;
  logic [SW-1:0] sum;
  logic [CNT_W-1:0] cnt_next;
`ifdef STAB_MON_ASSERT_EN
  if (MIN_STABLE < 2) begin : g_bad_min
    $error("MIN_STABLE must be >= 2");
  end
`endif
  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    stab_mon_chan #(.MIN_STABLE(MIN_STABLE)) u_chan (
      .clk(clk), .rst(rst), .en(en), .mode(mode_e'(mode)), .sig(sig[i]),
      .pass(pass[i]), .fail(fail[i]), .fail_next(fail_next[i])
    );
  end
  // count simultaneous fails and saturate the widened sum
  always_comb begin
    fail_pop = '0;
    for (int k = 0; k < WIDTH; k++) fail_pop = fail_pop + PW'(fail_next[k]);
    sum = SW'(fail_cnt) + SW'(fail_pop);
    cnt_next = (sum > SW'({CNT_W{1'b1}})) ? '1 : sum[CNT_W-1:0];
  end
  // sticky errors and counter; clear wins over same-cycle fails
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      err_sticky <= '0;
      fail_cnt   <= '0;
    end else begin
      err_sticky <= clear ? '0 : (err_sticky | fail_next);
      fail_cnt   <= clear ? '0 : cnt_next;
    end
endmodule
